regs_write_arbiter: RTL



---
 rtl/regs_write_arbiter_pkg.sv | 30 +++
 rtl/regs_write_arbiter_rr_pick4.sv | 34 +++
 rtl/regs_write_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/regs_write_arbiter_pkg.sv
//------------------------------------------------------------------------------
// regs_write_arbiter_pkg
// Shared FSM state encoding, requester count and default data width.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package regs_write_arbiter_pkg;

  localparam int c_nreq          = 4;
  localparam int c_width_default = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_WRITE = 3'd2,
    ST_ACK   = 3'd3,
    ST_CLEAR = 3'd4
  } state_t;

  function automatic logic [c_nreq-1:0] f_onehot(input logic [1:0] idx);
    logic [c_nreq-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regs_write_arbiter_rr_pick4.sv
//------------------------------------------------------------------------------
// rr_pick4
// Combinational 4-way round-robin picker: first set request after i_ptr.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_pick4
  import regs_write_arbiter_pkg::*;
(
  input  logic [3:0] i_req,
  input  logic [1:0] i_ptr,
  output logic       o_any,
  output logic [1:0] o_idx
);

  logic [1:0] w_cand;

  // Walk from the lowest priority (ptr itself) up to ptr+1 so the last hit wins.
  always_comb begin
    o_any  = |i_req;
    o_idx  = i_ptr;
    w_cand = i_ptr;
    for (int k = c_nreq; k >= 1; k--) begin
      w_cand = i_ptr + 2'(k);
      if (i_req[w_cand]) begin
        o_idx = w_cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/regs_write_arbiter.sv
//------------------------------------------------------------------------------
// regs_write_arbiter
// Round-robin write sequencer and clear serialiser for a shared register.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module regs_write_arbiter
  import regs_write_arbiter_pkg::*;
#(
  parameter int WIDTH = c_width_default
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [c_nreq-1:0]         i_req,
  input  logic [c_nreq*WIDTH-1:0]   i_wdata,
  input  logic                      i_clr_req,
  input  logic [WIDTH-1:0]          i_reg_q,
  output logic [WIDTH-1:0]          o_reg_d,
  output logic                      o_reg_clear,
  output logic [c_nreq-1:0]         o_grant,
  output logic [c_nreq-1:0]         o_ack,
  output logic                      o_clr_ack,
  output logic                      o_busy
);

  state_t             r_state;
  logic [1:0]         r_ptr;
  logic [1:0]         r_win;
  logic [WIDTH-1:0]   r_wbuf;
  logic [c_nreq-1:0]  r_grant;
  logic [c_nreq-1:0]  r_ack;
  logic               r_clr_ack;
  logic               r_busy;

  logic               w_any;
  logic [1:0]         w_idx;
  logic [WIDTH-1:0]   w_win_data;

  rr_pick4 u_pick (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_any (w_any),
    .o_idx (w_idx)
  );

  assign w_win_data = i_wdata[r_win*WIDTH +: WIDTH];

  // Output flags are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= 2'd3;
      r_win     <= 2'd0;
      r_wbuf    <= '0;
      r_grant   <= '0;
      r_ack     <= '0;
      r_clr_ack <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_clr_req) begin
            r_state   <= ST_CLEAR;
            r_clr_ack <= 1'b1;
            r_busy    <= 1'b1;
          end else if (w_any) begin
            r_state <= ST_GRANT;
            r_win   <= w_idx;
            r_grant <= f_onehot(w_idx);
            r_busy  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          r_state   <= ST_IDLE;
          r_clr_ack <= 1'b0;
          r_busy    <= 1'b0;
        end
        ST_GRANT: begin
          r_grant <= '0;
          if (i_req[r_win]) begin
            r_state <= ST_WRITE;
            r_wbuf  <= w_win_data;
          end else begin
            // Requester withdrew: abandon without touching the pointer.
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_WRITE: begin
          r_state <= ST_ACK;
          r_ack   <= f_onehot(r_win);
        end
        ST_ACK: begin
          r_state <= ST_IDLE;
          r_ack   <= '0;
          r_ptr   <= r_win;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_grant   <= '0;
          r_ack     <= '0;
          r_clr_ack <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  // The register reloads its own output except during the single WRITE beat.
  assign o_reg_d     = (r_state == ST_WRITE) ? r_wbuf : i_reg_q;
  assign o_reg_clear = rst | (r_state == ST_CLEAR);
  assign o_grant     = r_grant;
  assign o_ack       = r_ack;
  assign o_clr_ack   = r_clr_ack;
  assign o_busy      = r_busy;

endmodule

`default_nettype wire
